// File: rtl/tone_sequencer.sv
// tone_sequencer: fixed-priority arbiter and melody player driving the piezo note code.
// Optional silent gap between notes of a melody: define TSEQ_GAP_EN.
module tone_sequencer #(
    parameter int TICK_DIV = 1000,
    parameter int UNIT_MS  = 50,
    parameter int GAP_MS   = 20
) (
    input  logic       clk_1MHz,
    input  logic       rst,
    input  logic [3:0] req,
    output logic [3:0] mode,
    output logic       busy,
    output logic [1:0] cur_id,
    output logic       done
);
    localparam int MS_MAX = (4 * UNIT_MS > GAP_MS) ? 4 * UNIT_MS : GAP_MS;
    localparam int MS_W   = $clog2(MS_MAX + 1);
    localparam int PRE_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
`ifdef TSEQ_GAP_EN
    localparam logic [MS_W-1:0] GAP_LAST = MS_W'(GAP_MS - 1);
`endif

    typedef enum logic [1:0] {S_IDLE, S_NOTE, S_GAP} state_t;

    state_t           state_q, state_d;
    logic [3:0]       mode_q, mode_d;
    logic             busy_q, busy_d;
    logic [1:0]       cur_id_q, cur_id_d;
    logic             done_q, done_d;
    logic [2:0]       idx_q, idx_d;
    logic [2:0]       units_q, units_d;
    logic [PRE_W-1:0] pre_q, pre_d;
    logic [MS_W-1:0]  ms_q, ms_d;

    logic [1:0] win_id;
    logic       req_any;
    logic [6:0] first_entry;
    logic [6:0] next_entry;
    logic       tick_last;
    logic       note_end;
    logic       last_note_end;
    logic       accept;
`ifdef TSEQ_GAP_EN
    logic       gap_end;
`endif

    // Melody ROM entry {note, units}; units == 0 marks the end of a melody.
    function automatic logic [6:0] rom_entry(input logic [1:0] id, input logic [2:0] idx);
        logic [6:0] e;
        e = 7'd0;
        case ({id, idx})
            5'b00_000: e = {4'd5, 3'd1};
            5'b00_001: e = {4'd8, 3'd1};
            5'b01_000: e = {4'd3, 3'd2};
            5'b01_001: e = {4'd1, 3'd2};
            5'b10_000: e = {4'd1, 3'd2};
            5'b10_001: e = {4'd3, 3'd2};
            5'b10_010: e = {4'd5, 3'd2};
            5'b10_011: e = {4'd8, 3'd2};
            5'b11_000: e = {4'd5, 3'd2};
            5'b11_001: e = {4'd3, 3'd2};
            5'b11_010: e = {4'd1, 3'd4};
            default:   e = 7'd0;
        endcase
        return e;
    endfunction

    // Ascending scan: the highest set bit (highest priority) is the last to assign.
    always_comb begin
        req_any = |req;
        win_id  = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (req[i]) win_id = 2'(i);
        end
    end

    always_comb begin
        first_entry   = rom_entry(win_id, 3'd0);
        next_entry    = rom_entry(cur_id_q, idx_q + 3'd1);
        tick_last     = (pre_q == PRE_LAST);
        note_end      = (state_q == S_NOTE) && tick_last &&
                        (ms_q == MS_W'(int'(units_q) * UNIT_MS - 1));
        last_note_end = note_end && (next_entry[2:0] == 3'd0);
`ifdef TSEQ_GAP_EN
        gap_end       = (state_q == S_GAP) && tick_last && (ms_q == GAP_LAST);
`endif
        // The final cycle of a melody is already "not busy" for arbitration purposes.
        accept        = req_any &&
                        ((state_q == S_IDLE) || last_note_end || (win_id > cur_id_q));

        state_d  = state_q;
        mode_d   = mode_q;
        busy_d   = busy_q;
        cur_id_d = cur_id_q;
        done_d   = 1'b0;
        idx_d    = idx_q;
        units_d  = units_q;
        pre_d    = pre_q;
        ms_d     = ms_q;

        if (state_q != S_IDLE) begin
            pre_d = tick_last ? '0 : pre_q + PRE_W'(1);
            ms_d  = tick_last ? ms_q + MS_W'(1) : ms_q;
        end

        if (accept) begin
            state_d  = S_NOTE;
            mode_d   = first_entry[6:3];
            units_d  = first_entry[2:0];
            busy_d   = 1'b1;
            cur_id_d = win_id;
            idx_d    = 3'd0;
            pre_d    = '0;
            ms_d     = '0;
        end else if (last_note_end) begin
            state_d = S_IDLE;
            mode_d  = 4'd0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            idx_d   = 3'd0;
            units_d = 3'd0;
            pre_d   = '0;
            ms_d    = '0;
        end else if (note_end) begin
`ifdef TSEQ_GAP_EN
            state_d = S_GAP;
            mode_d  = 4'd0;
            pre_d   = '0;
            ms_d    = '0;
        end else if (gap_end) begin
`endif
            state_d = S_NOTE;
            mode_d  = next_entry[6:3];
            units_d = next_entry[2:0];
            idx_d   = idx_q + 3'd1;
            pre_d   = '0;
            ms_d    = '0;
        end
    end

    always_ff @(posedge clk_1MHz or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            mode_q   <= 4'd0;
            busy_q   <= 1'b0;
            cur_id_q <= 2'd0;
            done_q   <= 1'b0;
            idx_q    <= 3'd0;
            units_q  <= 3'd0;
            pre_q    <= '0;
            ms_q     <= '0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            busy_q   <= busy_d;
            cur_id_q <= cur_id_d;
            done_q   <= done_d;
            idx_q    <= idx_d;
            units_q  <= units_d;
            pre_q    <= pre_d;
            ms_q     <= ms_d;
        end
    end

    assign mode   = mode_q;
    assign busy   = busy_q;
    assign cur_id = cur_id_q;
    assign done   = done_q;

endmodule

// File: tb/tb_tone_sequencer.sv
// tb_tone_sequencer: directed and random event requests checked against a timeline model
// that derives the expected note code from the elapsed time since each melody started.
module tb_tone_sequencer;
    localparam int TICK_DIV = 10;
    localparam int UNIT_MS  = 2;
    localparam int GAP_MS   = 1;
    localparam int UNIT_CYC = UNIT_MS * TICK_DIV;
`ifdef TSEQ_GAP_EN
    localparam int GAP_CYC = GAP_MS * TICK_DIV;
`else
    localparam int GAP_CYC = 0;
`endif

    localparam int MEL_CNT [4]     = '{2, 2, 4, 3};
    localparam int MEL_NOTE[4][4]  = '{'{5, 8, 0, 0}, '{3, 1, 0, 0}, '{1, 3, 5, 8}, '{5, 3, 1, 0}};
    localparam int MEL_UNITS[4][4] = '{'{1, 1, 0, 0}, '{2, 2, 0, 0}, '{2, 2, 2, 2}, '{2, 2, 4, 0}};

    logic       clk_1MHz = 1'b0;
    logic       rst      = 1'b1;
    logic [3:0] req      = 4'd0;
    logic [3:0] mode;
    logic       busy;
    logic [1:0] cur_id;
    logic       done;

    tone_sequencer #(
        .TICK_DIV (TICK_DIV),
        .UNIT_MS  (UNIT_MS),
        .GAP_MS   (GAP_MS)
    ) dut (
        .clk_1MHz (clk_1MHz),
        .rst      (rst),
        .req      (req),
        .mode     (mode),
        .busy     (busy),
        .cur_id   (cur_id),
        .done     (done)
    );

    always #5 clk_1MHz = ~clk_1MHz;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int done_seen = 0;

    // Reference model: which melody is playing and the edge at which it started.
    bit m_play     = 1'b0;
    int m_id       = 0;
    int m_start    = 0;
    bit m_done_now = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int mel_len(input int id);
        int len;
        len = 0;
        for (int k = 0; k < MEL_CNT[id]; k++) len += MEL_UNITS[id][k] * UNIT_CYC;
        return len + (MEL_CNT[id] - 1) * GAP_CYC;
    endfunction

    function automatic int note_at(input int id, input int el);
        int t;
        t = el;
        for (int k = 0; k < MEL_CNT[id]; k++) begin
            if (t < MEL_UNITS[id][k] * UNIT_CYC) return MEL_NOTE[id][k];
            t -= MEL_UNITS[id][k] * UNIT_CYC;
            if (k < MEL_CNT[id] - 1) begin
                if (t < GAP_CYC) return 0;
                t -= GAP_CYC;
            end
        end
        return 0;
    endfunction

    function automatic int top_req(input logic [3:0] r);
        int w;
        w = -1;
        for (int i = 0; i < 4; i++) if (r[i]) w = i;
        return w;
    endfunction

    task automatic model_reset();
        m_play     = 1'b0;
        m_id       = 0;
        m_start    = 0;
        m_done_now = 1'b0;
    endtask

    task automatic model_edge(input logic [3:0] r);
        int el;
        int w;
        bit ending;
        bit take;
        cyc++;
        el     = cyc - m_start;
        ending = m_play && (el == mel_len(m_id));
        w      = top_req(r);
        take   = (w >= 0) && (!m_play || ending || (w > m_id));
        m_done_now = 1'b0;
        if (w >= 0)
            $display("edge %0d: req=%b winner=%0d %s", cyc, r, w, take ? "accepted" : "ignored");
        if (take) begin
            m_play  = 1'b1;
            m_id    = w;
            m_start = cyc;
        end else if (ending) begin
            m_play     = 1'b0;
            m_done_now = 1'b1;
        end
    endtask

    task automatic compare_outputs();
        int exp_mode;
        exp_mode = m_play ? note_at(m_id, cyc - m_start) : 0;
        check_val("mode", 32'(mode), 32'(exp_mode));
        check_val("busy", 32'(busy), 32'(m_play));
        check_val("cur_id", 32'(cur_id), 32'(m_id));
        check_val("done", 32'(done), m_play ? 32'd0 : 32'(m_done_now));
        if (done === 1'b1) done_seen++;
    endtask

    // Check what the previous edge produced, then drive r for the coming edge.
    task automatic step(input logic [3:0] r);
        @(negedge clk_1MHz);
        compare_outputs();
        req = r;
        @(posedge clk_1MHz);
        model_edge(r);
    endtask

    task automatic idle_steps(input int n);
        for (int i = 0; i < n; i++) step(4'd0);
    endtask

    task automatic apply_reset();
        @(negedge clk_1MHz);
        req = 4'd0;
        rst = 1'b1;
        #1;
        check_val("rst_mode", 32'(mode), 32'd0);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_done", 32'(done), 32'd0);
        check_val("rst_cur_id", 32'(cur_id), 32'd0);
        model_reset();
        @(posedge clk_1MHz);
        @(negedge clk_1MHz);
        rst = 1'b0;
    endtask

    initial begin
        int l_miss;
        logic [3:0] r;

        apply_reset();
        idle_steps(3);

        // HIT alone plays to completion with a single done pulse.
        done_seen = 0;
        step(4'b0001);
        idle_steps(mel_len(0) + 10);
        check_val("hit_done_count", 32'(done_seen), 32'd1);

        // Simultaneous MISS and HIT: MISS wins, HIT is dropped.
        done_seen = 0;
        step(4'b0011);
        idle_steps(mel_len(1) + 10);
        check_val("miss_done_count", 32'(done_seen), 32'd1);

        // OVER preempts START during its second note; only OVER pulses done.
        done_seen = 0;
        step(4'b0100);
        idle_steps(2 * UNIT_CYC + GAP_CYC + 10);
        step(4'b1000);
        idle_steps(mel_len(3) + 10);
        check_val("preempt_done_count", 32'(done_seen), 32'd1);

        // Lower-priority requests during OVER are ignored.
        done_seen = 0;
        step(4'b1000);
        idle_steps(30);
        step(4'b0001);
        idle_steps(50);
        step(4'b0100);
        idle_steps(mel_len(3));
        check_val("over_done_count", 32'(done_seen), 32'd1);

        // Reset in the middle of START, then stay idle.
        step(4'b0100);
        idle_steps(60);
        apply_reset();
        idle_steps(20);

        // MISS re-requested on the edge its last note ends: restart, no done.
        l_miss = mel_len(1);
        step(4'b0010);
        idle_steps(l_miss - 1);
        done_seen = 0;
        step(4'b0010);
        idle_steps(l_miss);
        check_val("restart_no_done", 32'(done_seen), 32'd0);
        idle_steps(10);

        // Random event traffic.
        for (int i = 0; i < 3000; i++) begin
            r = ($urandom_range(0, 39) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
            step(r);
        end
        idle_steps(200);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
